remap_cache_filler: RTL
=======================

REMAP_CACHE_FILLER -- requirements
Module: RemapCacheFiller

Interface
REQ-001 SHALL have parameter LBW, default 10, local address width; HBW = LBW-$clog2(VSIZE), NDATA = 1<<HBW lines.
REQ-002 SHALL have parameter DBW, default 16, data width per bank.
REQ-003 SHALL have parameter VSIZE, default 32, banks per line.
REQ-004 SHALL have parameter N_ICFG, default 4, config IDs; ICFG_BW = $clog2(N_ICFG+1).
REQ-005 Ports: i_clk in 1, sole clock; i_rst in 1, reset, synchronous, active-low.
REQ-006 Ports: alloc_rdy in 1 / alloc_ack out 1, fill request handshake; i_alloc_id in ICFG_BW; i_alloc_len in HBW+1, lines to fill.
REQ-007 Ports: dramrd_rdy in 1 / dramrd_ack out 1, incoming line handshake; i_dramrd in DBW x VSIZE, line data.
REQ-008 Ports: wad_dval out 1; o_wid out ICFG_BW; o_whiaddr out HBW; o_wdata out DBW x VSIZE: cache write port.
REQ-009 Ports: free_dval in 1; i_false_alloc in 1; i_free_id in ICFG_BW: line-retire notification from cache.
REQ-010 Ports: o_avail out (HBW+1) x N_ICFG, lines written and not freed per ID; o_occupancy out HBW+1; o_underflow out 1, sticky error.

Function
REQ-011 Handshakes SHALL follow codebase rdyack: transfer in the cycle ack=1; ack only asserted while rdy=1; ack is a one-cycle pulse per transfer.
REQ-012 FSM SHALL have states IDLE and FILL; reset state IDLE.
REQ-013 IDLE with alloc_rdy=1: alloc_ack=1 that cycle; latch id and len; next state FILL if len>0, else stay IDLE.
REQ-014 alloc_ack SHALL be 0 in FILL.
REQ-015 FILL: dramrd_ack = dramrd_rdy && occupancy < NDATA; each ack decrements remaining count; ack of last line returns to IDLE next cycle.
REQ-016 Accepted line in cycle t SHALL appear at t+1: wad_dval=1, o_wid=latched id, o_whiaddr=wptr, o_wdata=registered line; wad_dval=0 otherwise.
REQ-017 wptr SHALL increment by 1 per accepted line, modulo NDATA (NDATA-1 wraps to 0).
REQ-018 occupancy and o_avail[id] SHALL increment at acceptance (cycle t, visible t+1).
REQ-019 free_dval=1 with i_false_alloc=0 SHALL decrement occupancy and o_avail[i_free_id]; with i_false_alloc=1 no counter changes.
REQ-020 Simultaneous acceptance and valid free: occupancy unchanged; o_avail adjusted per ID (net zero if same ID).
REQ-021 Valid free with occupancy=0 or o_avail[i_free_id]=0: counter unchanged, o_underflow set until reset.
REQ-022 i_free_id >= N_ICFG SHALL be ignored and set o_underflow.
REQ-023 Full (occupancy=NDATA): dramrd_ack held 0, state and remaining count hold.

Reset
REQ-024 On i_rst=0 at clock edge: state IDLE, wptr=0, occupancy=0, all o_avail=0, o_underflow=0, wad_dval=0, alloc_ack=0, dramrd_ack=0, o_wid=0, o_whiaddr=0, o_wdata=0.
REQ-025 Reset mid-FILL SHALL abandon remaining count; no wad_dval in cycle after reset.

Configuration
REQ-026 Macro REMAP_FILL_FREE_BYPASS_EN: defined -> when full, a same-cycle valid free permits dramrd_ack (occupancy stays NDATA); undefined -> REQ-023 strict, no bypass.

Verification
REQ-027 Alloc id=1 len=3, dramrd_rdy held -> 3 acks back-to-back, wad_dval at whiaddr 0,1,2 with o_wid=1; o_avail[1]=3; IDLE after.
REQ-028 Alloc len=0 -> single alloc_ack, no dramrd_ack, state IDLE.
REQ-029 Fill NDATA lines, then 1 more requested -> dramrd_ack 0; one free (false_alloc=0) -> next line written at whiaddr 0 (wrap); bypass build: accepted same cycle as free.
REQ-030 Free with i_false_alloc=1 while occupancy=5 -> occupancy 5, o_avail unchanged.
REQ-031 Free when occupancy=0 -> o_underflow=1, counters 0; stays 1 until i_rst=0.
REQ-032 Reset asserted after 2 of 4 lines -> all outputs zero next cycle, IDLE, new alloc writes from whiaddr 0.

Source files
------------

// File: rtl/remap_cache_filler_if.sv
// Bundle of the filler's allocation, DRAM-line, cache-write and line-retire signals.
// The filler itself connects through the slave modport.
interface remap_cache_filler_if #(
  parameter int LBW    = 10,
  parameter int DBW    = 16,
  parameter int VSIZE  = 32,
  parameter int N_ICFG = 4
);
  localparam int HBW     = LBW - $clog2(VSIZE);
  localparam int ICFG_BW = $clog2(N_ICFG + 1);

  logic                             alloc_rdy;
  logic                             alloc_ack;
  logic [ICFG_BW-1:0]               i_alloc_id;
  logic [HBW:0]                     i_alloc_len;
  logic                             dramrd_rdy;
  logic                             dramrd_ack;
  logic [VSIZE-1:0][DBW-1:0]        i_dramrd;
  logic                             wad_dval;
  logic [ICFG_BW-1:0]               o_wid;
  logic [HBW-1:0]                   o_whiaddr;
  logic [VSIZE-1:0][DBW-1:0]        o_wdata;
  logic                             free_dval;
  logic                             i_false_alloc;
  logic [ICFG_BW-1:0]               i_free_id;
  logic [N_ICFG-1:0][HBW:0]         o_avail;
  logic [HBW:0]                     o_occupancy;
  logic                             o_underflow;

  modport master (
    output alloc_rdy, i_alloc_id, i_alloc_len, dramrd_rdy, i_dramrd,
           free_dval, i_false_alloc, i_free_id,
    input  alloc_ack, dramrd_ack, wad_dval, o_wid, o_whiaddr, o_wdata,
           o_avail, o_occupancy, o_underflow
  );

  modport slave (
    input  alloc_rdy, i_alloc_id, i_alloc_len, dramrd_rdy, i_dramrd,
           free_dval, i_false_alloc, i_free_id,
    output alloc_ack, dramrd_ack, wad_dval, o_wid, o_whiaddr, o_wdata,
           o_avail, o_occupancy, o_underflow
  );
endinterface

// File: rtl/remap_cache_filler.sv
// Fills a circular line cache from DRAM per allocation request and tracks per-ID live lines.
// Option REMAP_FILL_FREE_BYPASS_EN: when full, a same-cycle valid free lets a new line in.
module remap_cache_filler #(
  parameter int LBW    = 10,
  parameter int DBW    = 16,
  parameter int VSIZE  = 32,
  parameter int N_ICFG = 4
) (
  input logic                  i_clk,
  input logic                  i_rst,
  remap_cache_filler_if.slave  bus
);
  localparam int HBW     = LBW - $clog2(VSIZE);
  localparam int ICFG_BW = $clog2(N_ICFG + 1);
  localparam logic [HBW:0] FULL_OCC = (HBW+1)'(1 << HBW);

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t                    state_q;
  logic [ICFG_BW-1:0]        id_q;
  logic [HBW:0]              rem_q;
  logic [HBW-1:0]            wptr_q;
  logic [HBW:0]              occ_q;
  logic [HBW:0]              occ_d;
  logic [HBW:0]              avail_q [N_ICFG];
  logic                      underflow_q;
  logic                      wad_dval_q;
  logic [ICFG_BW-1:0]        wid_q;
  logic [HBW-1:0]            whiaddr_q;
  logic [VSIZE-1:0][DBW-1:0] wdata_q;

  logic [N_ICFG-1:0] free_sel;
  logic [N_ICFG-1:0] fill_sel;
  logic [N_ICFG-1:0] avail_nz;
  logic              id_ok;
  logic              free_req;
  logic              free_ok;
  logic              bad_free;
  logic              full;
  logic              room;
  logic              alloc_ack;
  logic              dram_ack;

  genvar gi;
  generate
    for (gi = 0; gi < N_ICFG; gi++) begin : g_id
      logic inc;
      logic dec;
      assign free_sel[gi] = (bus.i_free_id == ICFG_BW'(gi));
      assign fill_sel[gi] = (id_q == ICFG_BW'(gi));
      assign avail_nz[gi] = |avail_q[gi];
      assign inc          = dram_ack && fill_sel[gi];
      assign dec          = free_ok && free_sel[gi];

      // Net-zero when the filling ID and the retiring ID coincide.
      always_ff @(posedge i_clk) begin
        if (!i_rst) begin
          avail_q[gi] <= '0;
        end else if (inc && !dec) begin
          avail_q[gi] <= avail_q[gi] + 1'b1;
        end else if (dec && !inc) begin
          avail_q[gi] <= avail_q[gi] - 1'b1;
        end
      end

      assign bus.o_avail[gi] = avail_q[gi];
    end
  endgenerate

  always_comb begin
    id_ok    = (bus.i_free_id < ICFG_BW'(N_ICFG));
    free_req = bus.free_dval && !bus.i_false_alloc;
    free_ok  = free_req && (|(free_sel & avail_nz)) && (occ_q != '0);
    bad_free = (bus.free_dval && !id_ok) || (free_req && !free_ok);
    full     = (occ_q == FULL_OCC);
`ifdef REMAP_FILL_FREE_BYPASS_EN
    room     = !full || free_ok;
`else
    room     = !full;
`endif
    alloc_ack = i_rst && (state_q == S_IDLE) && bus.alloc_rdy;
    dram_ack  = i_rst && (state_q == S_FILL) && bus.dramrd_rdy && room;
    occ_d     = occ_q;
    if (dram_ack && !free_ok) begin
      occ_d = occ_q + 1'b1;
    end else if (free_ok && !dram_ack) begin
      occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= S_IDLE;
      id_q        <= '0;
      rem_q       <= '0;
      wptr_q      <= '0;
      occ_q       <= '0;
      underflow_q <= 1'b0;
      wad_dval_q  <= 1'b0;
      wid_q       <= '0;
      whiaddr_q   <= '0;
      wdata_q     <= '0;
    end else begin
      occ_q      <= occ_d;
      wad_dval_q <= dram_ack;
      if (bad_free) begin
        underflow_q <= 1'b1;
      end
      if (dram_ack) begin
        wid_q     <= id_q;
        whiaddr_q <= wptr_q;
        wdata_q   <= bus.i_dramrd;
        wptr_q    <= wptr_q + 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (alloc_ack) begin
            id_q  <= bus.i_alloc_id;
            rem_q <= bus.i_alloc_len;
            if (bus.i_alloc_len != '0) begin
              state_q <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (dram_ack) begin
            rem_q <= rem_q - 1'b1;
            if (rem_q == (HBW+1)'(1)) begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.alloc_ack   = alloc_ack;
  assign bus.dramrd_ack  = dram_ack;
  assign bus.wad_dval    = wad_dval_q;
  assign bus.o_wid       = wid_q;
  assign bus.o_whiaddr   = whiaddr_q;
  assign bus.o_wdata     = wdata_q;
  assign bus.o_occupancy = occ_q;
  assign bus.o_underflow = underflow_q;
endmodule
